// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes opcode/funct into alu_ctrl, selects operand B, and issues
// {A, B, ctrl} through a 2-entry skid-buffered valid/ready register. Optional: ALU_ISSUE_TRAP_EN.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [XLEN-1:0]   rs_val,
  input  logic [XLEN-1:0]   rt_val,
  input  logic [15:0]       imm16,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl
`ifdef ALU_ISSUE_TRAP_EN
  , output logic            ill_instr
`endif
);

  localparam logic [CTRL_W-1:0] C_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] C_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] C_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] C_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] C_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] C_NOR = 4'b1100;
  localparam logic [CTRL_W-1:0] C_UNS = 4'b1111;

  logic [XLEN-1:0]   imm_sx, imm_zx, dec_b;
  logic [CTRL_W-1:0] dec_ctrl;

  assign imm_sx = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm_zx = {{(XLEN-16){1'b0}}, imm16};

  always_comb begin
    dec_b    = rt_val;
    dec_ctrl = C_UNS;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001: dec_ctrl = C_ADD;
          6'b100010, 6'b100011: dec_ctrl = C_SUB;
          6'b100100:            dec_ctrl = C_AND;
          6'b100101:            dec_ctrl = C_OR;
          6'b100111:            dec_ctrl = C_NOR;
          6'b101010:            dec_ctrl = C_SLT;
          default:              dec_ctrl = C_UNS;
        endcase
      end
      6'b100011, 6'b101011, 6'b001000: begin dec_ctrl = C_ADD; dec_b = imm_sx; end
      6'b001010:                       begin dec_ctrl = C_SLT; dec_b = imm_sx; end
      6'b001100:                       begin dec_ctrl = C_AND; dec_b = imm_zx; end
      6'b001101:                       begin dec_ctrl = C_OR;  dec_b = imm_zx; end
      6'b000100:                             dec_ctrl = C_SUB;
      default: begin dec_ctrl = C_UNS; dec_b = rt_val; end
    endcase
  end

  logic              out_valid_q, skid_valid_q, in_ready_q;
  logic [XLEN-1:0]   out_a_q, out_b_q, skid_a_q, skid_b_q;
  logic [CTRL_W-1:0] out_ctrl_q, skid_ctrl_q;
`ifdef ALU_ISSUE_TRAP_EN
  logic              out_ill_q, skid_ill_q;
`endif

  logic accept, slot_free;
  logic out_valid_d, skid_valid_d;
  logic ld_out_skid, ld_out_in, ld_skid;

  assign accept    = in_valid && in_ready_q && !flush;
  assign slot_free = !out_valid_q || out_ready;

  // Skid always drains first so FIFO order holds; flush overrides everything.
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    ld_out_skid  = 1'b0;
    ld_out_in    = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      if (skid_valid_q) begin
        ld_out_skid  = 1'b1;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        ld_skid      = accept;
      end else begin
        out_valid_d = accept;
        ld_out_in   = accept;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      ld_skid      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_ctrl_q   <= '0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      skid_ctrl_q  <= '0;
`ifdef ALU_ISSUE_TRAP_EN
      out_ill_q    <= 1'b0;
      skid_ill_q   <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
      if (ld_out_skid) begin
        out_a_q    <= skid_a_q;
        out_b_q    <= skid_b_q;
        out_ctrl_q <= skid_ctrl_q;
`ifdef ALU_ISSUE_TRAP_EN
        out_ill_q  <= skid_ill_q;
`endif
      end else if (ld_out_in) begin
        out_a_q    <= rs_val;
        out_b_q    <= dec_b;
        out_ctrl_q <= dec_ctrl;
`ifdef ALU_ISSUE_TRAP_EN
        out_ill_q  <= (dec_ctrl == C_UNS);
`endif
      end
      if (ld_skid) begin
        skid_a_q    <= rs_val;
        skid_b_q    <= dec_b;
        skid_ctrl_q <= dec_ctrl;
`ifdef ALU_ISSUE_TRAP_EN
        skid_ill_q  <= (dec_ctrl == C_UNS);
`endif
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_a     = out_a_q;
  assign alu_b     = out_b_q;
  assign alu_ctrl  = out_ctrl_q;
`ifdef ALU_ISSUE_TRAP_EN
  assign ill_instr = out_ill_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure ordering, flush, reset.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_val, rt_val, alu_a, alu_b;
  logic [15:0] imm16;
  logic [3:0]  alu_ctrl;
`ifdef ALU_ISSUE_TRAP_EN
  logic        ill_instr;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl)
`ifdef ALU_ISSUE_TRAP_EN
    , .ill_instr(ill_instr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
    in_valid = v; opcode = op; funct = fn; rs_val = rs; rt_val = rt; imm16 = im;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c);
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_a"}, alu_a, a);
    check({tag, "_b"}, alu_b, b);
    check({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, c});
`ifdef ALU_ISSUE_TRAP_EN
    check({tag, "_ill"}, {31'd0, ill_instr}, {31'd0, (c == 4'hF)});
`endif
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 32'd0, 32'd0, 16'd0);
    tick(); tick();
    reset = 1'b0;
    // reset / idle state
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_vld", {31'd0, out_valid}, 32'd0);
      check("idle_rdy", {31'd0, in_ready}, 32'd1);
      check("idle_ctrl", {28'd0, alu_ctrl}, 32'd0);
    end
    check("idle_a", alu_a, 32'd0);

    // add
    drive(1'b1, 6'b000000, 6'b100000, 32'd5, 32'd7, 16'h0);
    tick(); chk_word("add", 32'd5, 32'd7, 4'b0010);
    // back-to-back decode vectors
    drive(1'b1, 6'b001000, 6'd0, 32'd3, 32'h55, 16'hFFFF);
    tick(); chk_word("addi", 32'd3, 32'hFFFF_FFFF, 4'b0010);
    drive(1'b1, 6'b001100, 6'd0, 32'd4, 32'h55, 16'hFFFF);
    tick(); chk_word("andi", 32'd4, 32'h0000_FFFF, 4'b0000);
    drive(1'b1, 6'b000000, 6'b100011, 32'd9, 32'd2, 16'h0);
    tick(); chk_word("subu", 32'd9, 32'd2, 4'b0110);
    drive(1'b1, 6'b000000, 6'b100111, 32'd1, 32'd6, 16'h0);
    tick(); chk_word("nor", 32'd1, 32'd6, 4'b1100);
    drive(1'b1, 6'b000000, 6'b101010, 32'd1, 32'd8, 16'h0);
    tick(); chk_word("slt", 32'd1, 32'd8, 4'b0111);
    drive(1'b1, 6'b000000, 6'b100101, 32'd1, 32'd8, 16'h0);
    tick(); chk_word("or", 32'd1, 32'd8, 4'b0001);
    drive(1'b1, 6'b001010, 6'd0, 32'd2, 32'd1, 16'h8000);
    tick(); chk_word("slti", 32'd2, 32'hFFFF_8000, 4'b0111);
    drive(1'b1, 6'b001101, 6'd0, 32'd2, 32'd1, 16'h8000);
    tick(); chk_word("ori", 32'd2, 32'h0000_8000, 4'b0001);
    drive(1'b1, 6'b000100, 6'd0, 32'd2, 32'd9, 16'h0010);
    tick(); chk_word("beq", 32'd2, 32'd9, 4'b0110);
    drive(1'b1, 6'b100011, 6'd0, 32'h100, 32'd9, 16'h0004);
    tick(); chk_word("lw", 32'h100, 32'd4, 4'b0010);
    drive(1'b1, 6'b111111, 6'd0, 32'd6, 32'hAB, 16'h1234);
    tick(); chk_word("unsup_op", 32'd6, 32'hAB, 4'b1111);
    drive(1'b1, 6'b000000, 6'b000000, 32'd7, 32'hCD, 16'h1234);
    tick(); chk_word("unsup_fn", 32'd7, 32'hCD, 4'b1111);
    drive(1'b0, 6'd0, 6'b100000, 32'd0, 32'd0, 16'h0);
    tick();
    check("drain_vld", {31'd0, out_valid}, 32'd0);
    check("drain_hold_a", alu_a, 32'd7);

    // backpressure: three back-to-back words, ALU stalled
    out_ready = 1'b0;
    drive(1'b1, 6'b000000, 6'b100000, 32'd1, 32'd0, 16'h0);
    tick(); chk_word("bp_w1", 32'd1, 32'd0, 4'b0010);
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 6'b000000, 6'b100000, 32'd2, 32'd0, 16'h0);
    tick(); chk_word("bp_hold1", 32'd1, 32'd0, 4'b0010);
    check("bp_rdy2", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 6'b000000, 6'b100000, 32'd3, 32'd0, 16'h0);
    tick(); chk_word("bp_hold2", 32'd1, 32'd0, 4'b0010);
    check("bp_rdy3", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick(); chk_word("bp_w2", 32'd2, 32'd0, 4'b0010);
    check("bp_rdy4", {31'd0, in_ready}, 32'd1);
    tick(); chk_word("bp_w3", 32'd3, 32'd0, 4'b0010);
    in_valid = 1'b0;
    tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // flush with out and skid full and input presented
    out_ready = 1'b0;
    drive(1'b1, 6'b000000, 6'b100000, 32'h11, 32'd0, 16'h0);
    tick();
    drive(1'b1, 6'b000000, 6'b100000, 32'h12, 32'd0, 16'h0);
    tick();
    check("fl_full_rdy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 6'b000000, 6'b100000, 32'h13, 32'd0, 16'h0);
    flush = 1'b1;
    tick();
    check("fl_vld", {31'd0, out_valid}, 32'd0);
    check("fl_rdy", {31'd0, in_ready}, 32'd1);
    check("fl_data_kept", alu_a, 32'h11);
    // flush also drops an input that would otherwise be accepted
    drive(1'b1, 6'b000000, 6'b100000, 32'h21, 32'd0, 16'h0);
    tick();
    check("fl2_vld", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_after_vld", {31'd0, out_valid}, 32'd0);
    check("fl_after_a", alu_a, 32'h11);

    // reset mid-transfer
    drive(1'b1, 6'b111111, 6'd0, 32'h44, 32'h55, 16'h0);
    out_ready = 1'b0;
    tick(); chk_word("rst_pre", 32'h44, 32'h55, 4'b1111);
    reset = 1'b1;
    tick();
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
`ifdef ALU_ISSUE_TRAP_EN
    check("rst_ill", {31'd0, ill_instr}, 32'd0);
`endif
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_vld", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
